// File: rtl/seg7_scan_bcd_if.sv
// Sample/handshake/display bundle for the scanned seven-segment BCD driver.
interface seg7_scan_bcd_if #(
    parameter int NUM_CH = 3,
    parameter int MAG_W  = 4,
    parameter int N_AN   = 8
);
    logic                        data_valid;
    logic [NUM_CH*(MAG_W+1)-1:0] acl_data;
    logic                        disp_en;
    logic                        busy;
    logic                        done;
    logic [6:0]                  seg;
    logic                        dp;
    logic [N_AN-1:0]             an;

    modport master (
        output data_valid, acl_data, disp_en,
        input  busy, done, seg, dp, an
    );

    modport slave (
        input  data_valid, acl_data, disp_en,
        output busy, done, seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_bcd.sv
// Multi-channel sign-magnitude to BCD converter with atomic commit and
// time-multiplexed seven-segment scan (sign on the decimal point).
module seg7_scan_bcd #(
    parameter int NUM_CH      = 3,
    parameter int MAG_W       = 4,
    parameter int BCD_DIGITS  = 2,
    parameter int REFRESH_CNT = 100000,
    parameter int LZ_BLANK    = 0
) (
    input logic           CLK100MHZ,
    input logic           reset,
    seg7_scan_bcd_if.slave bus
);
    function automatic int dec_digits(input int w);
        int v;
        int n;
        v = (2 ** w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int N_AN  = NUM_CH * (BCD_DIGITS + 1) - 1;
    localparam int NEED  = dec_digits(MAG_W);
    localparam int IDIG  = (NEED > BCD_DIGITS) ? NEED : BCD_DIGITS;
    localparam int BW    = 4 * IDIG;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam int IDX_W = (N_AN > 1) ? $clog2(N_AN) : 1;
    localparam int TMR_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    localparam logic [6:0] BLANK = 7'b111_1111;
    localparam logic [6:0] DASH  = 7'b111_1110;

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state;
    logic [CH_W-1:0]  ch_idx;
    logic [BIT_W-1:0] bit_idx;
    logic [MAG_W-1:0] mag      [NUM_CH];
    logic             sgn_in   [NUM_CH];
    logic [BW-1:0]    work     [NUM_CH];
    logic [BW-1:0]    work_nxt [NUM_CH];
    logic [3:0]       dig      [NUM_CH][BCD_DIGITS];
    logic             ovf      [NUM_CH];
    logic             sgn      [NUM_CH];
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] v, input logic b);
        logic [BW-1:0] t;
        t = v;
        for (int i = 0; i < IDIG; i++) begin
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[BW-2:0], b};
    endfunction

    function automatic logic over(input logic [BW-1:0] v);
        logic o;
        o = 1'b0;
        for (int j = BCD_DIGITS; j < IDIG; j++) o = o | (v[4*j +: 4] != 4'd0);
        return o;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b000_0001;
            4'd1:    return 7'b100_1111;
            4'd2:    return 7'b001_0010;
            4'd3:    return 7'b000_0110;
            4'd4:    return 7'b100_1100;
            4'd5:    return 7'b010_0100;
            4'd6:    return 7'b010_0000;
            4'd7:    return 7'b000_1111;
            4'd8:    return 7'b000_0000;
            4'd9:    return 7'b000_0100;
            default: return BLANK;
        endcase
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            work_nxt[c] = work[c];
            if (CH_W'(c) == ch_idx) work_nxt[c] = dabble(work[c], mag[c][MAG_W-1]);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            ch_idx   <= '0;
            bit_idx  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                mag[c]    <= '0;
                sgn_in[c] <= 1'b0;
                work[c]   <= '0;
                ovf[c]    <= 1'b0;
                sgn[c]    <= 1'b0;
                for (int d = 0; d < BCD_DIGITS; d++) dig[c][d] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.data_valid) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            mag[c]    <= bus.acl_data[c*(MAG_W+1) +: MAG_W];
                            sgn_in[c] <= bus.acl_data[c*(MAG_W+1)+MAG_W];
                            work[c]   <= '0;
                        end
                        ch_idx   <= '0;
                        bit_idx  <= '0;
                        bus.busy <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        work[c] <= work_nxt[c];
                        if (CH_W'(c) == ch_idx) mag[c] <= mag[c] << 1;
                    end
                    if (bit_idx == BIT_W'(MAG_W - 1)) begin
                        bit_idx <= '0;
                        if (ch_idx == CH_W'(NUM_CH - 1)) begin
                            // Last shift lands straight in the display registers.
                            for (int c = 0; c < NUM_CH; c++) begin
                                ovf[c] <= over(work_nxt[c]);
                                sgn[c] <= sgn_in[c];
                                for (int d = 0; d < BCD_DIGITS; d++)
                                    dig[c][d] <= work_nxt[c][4*d +: 4];
                            end
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        logic hz;
        hz      = 1'b1;
        seg_nxt = BLANK;
        dp_nxt  = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (idx == IDX_W'(c * (BCD_DIGITS + 1) + d)) begin
                    hz = 1'b1;
                    for (int j = 0; j < BCD_DIGITS; j++)
                        if (j >= d && dig[c][j] != 4'd0) hz = 1'b0;
                    if (ovf[c])
                        seg_nxt = DASH;
                    else if (LZ_BLANK != 0 && d != 0 && hz)
                        seg_nxt = BLANK;
                    else
                        seg_nxt = glyph(dig[c][d]);
                    dp_nxt = (d == 0) ? ~sgn[c] : 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            idx     <= '0;
            tmr     <= '0;
            bus.an  <= '1;
            bus.seg <= BLANK;
            bus.dp  <= 1'b1;
        end else begin
            if (tmr == TMR_W'(REFRESH_CNT - 1)) begin
                tmr <= '0;
                idx <= (idx == IDX_W'(N_AN - 1)) ? '0 : idx + 1'b1;
            end else begin
                tmr <= tmr + 1'b1;
            end
            bus.an  <= bus.disp_en ? ~(N_AN'(1) << idx) : '1;
            bus.seg <= seg_nxt;
            bus.dp  <= dp_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Bench for seg7_scan_bcd: decimal-arithmetic display model checked every
// cycle on three configurations, plus literal scan/timing expectations.
module tb_seg7_scan_bcd;
    localparam int R   = 4;
    localparam int NAN = 8;
    localparam int ND  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_bcd_if #(.NUM_CH(3), .MAG_W(4), .N_AN(8)) ifa ();
    seg7_scan_bcd_if #(.NUM_CH(3), .MAG_W(4), .N_AN(8)) ifb ();
    seg7_scan_bcd_if #(.NUM_CH(3), .MAG_W(7), .N_AN(8)) ifc ();

    seg7_scan_bcd #(.NUM_CH(3), .MAG_W(4), .BCD_DIGITS(2),
                    .REFRESH_CNT(R), .LZ_BLANK(0)) u_a (
        .CLK100MHZ(clk), .reset(reset), .bus(ifa));
    seg7_scan_bcd #(.NUM_CH(3), .MAG_W(4), .BCD_DIGITS(2),
                    .REFRESH_CNT(R), .LZ_BLANK(1)) u_b (
        .CLK100MHZ(clk), .reset(reset), .bus(ifb));
    seg7_scan_bcd #(.NUM_CH(3), .MAG_W(7), .BCD_DIGITS(2),
                    .REFRESH_CNT(R), .LZ_BLANK(0)) u_c (
        .CLK100MHZ(clk), .reset(reset), .bus(ifc));

    int p_mag_w [3] = '{4, 4, 7};
    int p_lz    [3] = '{0, 1, 0};

    int   m_mag  [3][3];
    bit   m_sgn  [3][3];
    int   l_mag  [3][3];
    bit   l_sgn  [3][3];
    int   m_left [3];
    logic [7:0] e_an  [3];
    logic [6:0] e_seg [3];
    logic e_dp [3];
    logic e_busy [3];
    logic e_done [3];
    int   m_tick = 0;
    bit   m_valid = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b000_0001;
            1: return 7'b100_1111;
            2: return 7'b001_0010;
            3: return 7'b000_0110;
            4: return 7'b100_1100;
            5: return 7'b010_0100;
            6: return 7'b010_0000;
            7: return 7'b000_1111;
            8: return 7'b000_0000;
            9: return 7'b000_0100;
            default: return 7'b111_1111;
        endcase
    endfunction

    // Model: position -> channel/digit by division, digits by decimal arithmetic.
    task automatic model_step(input int i, input bit dv, input logic [23:0] data, input bit en);
        int pos, ch, d, v, w;
        pos = ((m_tick - 1) / R) % NAN;
        ch  = pos / (ND + 1);
        d   = pos % (ND + 1);
        e_an[i]  = en ? ~(8'd1 << pos) : 8'hFF;
        e_seg[i] = 7'b111_1111;
        e_dp[i]  = 1'b1;
        if (d != ND) begin
            v = m_mag[i][ch];
            if (v >= 10 ** ND) e_seg[i] = 7'b111_1110;
            else if (p_lz[i] != 0 && d > 0 && v < 10 ** d) e_seg[i] = 7'b111_1111;
            else e_seg[i] = glyph((v / (10 ** d)) % 10);
            if (d == 0 && m_sgn[i][ch]) e_dp[i] = 1'b0;
        end
        e_done[i] = 1'b0;
        if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                for (int c = 0; c < 3; c++) begin
                    m_mag[i][c] = l_mag[i][c];
                    m_sgn[i][c] = l_sgn[i][c];
                end
                e_done[i] = 1'b1;
            end
        end else if (dv) begin
            w = p_mag_w[i];
            for (int c = 0; c < 3; c++) begin
                l_mag[i][c] = 0;
                for (int b = 0; b < w; b++)
                    if (data[c*(w+1)+b]) l_mag[i][c] += (1 << b);
                l_sgn[i][c] = data[c*(w+1)+w];
            end
            m_left[i] = 3 * w;
        end
        e_busy[i] = (m_left[i] > 0);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_tick  = 0;
            m_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                m_left[i] = 0;
                for (int c = 0; c < 3; c++) begin
                    m_mag[i][c] = 0;
                    m_sgn[i][c] = 1'b0;
                end
                e_an[i]   = 8'hFF;
                e_seg[i]  = 7'b111_1111;
                e_dp[i]   = 1'b1;
                e_busy[i] = 1'b0;
                e_done[i] = 1'b0;
            end
        end else if (m_valid) begin
            m_tick++;
            model_step(0, ifa.data_valid, 24'(ifa.acl_data), ifa.disp_en);
            model_step(1, ifb.data_valid, 24'(ifb.acl_data), ifb.disp_en);
            model_step(2, ifc.data_valid, ifc.acl_data, ifc.disp_en);
        end
    end

    task automatic cmp1(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, i, $time, got, want);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [7:0] an, input logic [6:0] seg,
                            input logic dp, input logic busy, input logic done);
        cmp1("an", i, an, e_an[i]);
        cmp1("seg", i, seg, e_seg[i]);
        cmp1("dp", i, dp, e_dp[i]);
        cmp1("busy", i, busy, e_busy[i]);
        cmp1("done", i, done, e_done[i]);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_inst(0, ifa.an, ifa.seg, ifa.dp, ifa.busy, ifa.done);
            cmp_inst(1, ifb.an, ifb.seg, ifb.dp, ifb.busy, ifb.done);
            cmp_inst(2, ifc.an, ifc.seg, ifc.dp, ifc.busy, ifc.done);
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] an_of(input int i);
        case (i)
            0: return ifa.an;
            1: return ifb.an;
            default: return ifc.an;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input int i);
        case (i)
            0: return ifa.seg;
            1: return ifb.seg;
            default: return ifc.seg;
        endcase
    endfunction

    function automatic logic dp_of(input int i);
        case (i)
            0: return ifa.dp;
            1: return ifb.dp;
            default: return ifc.dp;
        endcase
    endfunction

    task automatic scan_lit(input string name, input int i, input int pos,
                            input logic [6:0] s, input logic d);
        int k;
        k = 0;
        while (an_of(i) !== ~(8'd1 << pos) && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (k >= 80) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: anode %0d not selected, got an %0h", name, pos, an_of(i));
        end else begin
            lit({name, " seg"}, seg_of(i), s);
            lit({name, " dp"}, dp_of(i), d);
        end
    endtask

    task automatic wait_done_a(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            ifa.data_valid = 1'b0;
            if (ifa.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    localparam logic [6:0] G0 = 7'b000_0001;
    localparam logic [6:0] G1 = 7'b100_1111;
    localparam logic [6:0] G3 = 7'b000_0110;
    localparam logic [6:0] G5 = 7'b010_0100;
    localparam logic [6:0] G9 = 7'b000_0100;
    localparam logic [6:0] GB = 7'b111_1111;
    localparam logic [6:0] GD = 7'b111_1110;

    initial begin
        int   done_at;
        int   busy_n;
        int   len;
        bit   ok;
        bit   done_seen;
        logic [7:0] cur;

        reset = 1'b1;
        ifa.data_valid = 0; ifb.data_valid = 0; ifc.data_valid = 0;
        ifa.acl_data = '0;  ifb.acl_data = '0;  ifc.acl_data = '0;
        ifa.disp_en = 1;    ifb.disp_en = 1;    ifc.disp_en = 1;
        repeat (3) @(negedge clk);
        lit("reset an", ifa.an, 8'hFF);
        lit("reset seg", ifa.seg, 7'h7F);
        lit("reset dp", ifa.dp, 1'b1);
        lit("reset busy", ifa.busy, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // X=-13, Y=+5, Z=-0 ; C: ch0=+127, ch1=+99, ch2=-100
        ifa.acl_data = 15'b11101_00101_10000;
        ifb.acl_data = 15'b11101_00101_10000;
        ifc.acl_data = {1'b1, 7'd100, 1'b0, 7'd99, 1'b0, 7'd127};
        ifa.data_valid = 1; ifb.data_valid = 1; ifc.data_valid = 1;
        done_at = -1;
        busy_n  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifa.data_valid = 0; ifb.data_valid = 0; ifc.data_valid = 0;
            end
            if (k == 5) begin
                ifa.acl_data   = 15'b00111_00111_00111;
                ifa.data_valid = 1;
            end
            if (k == 6) ifa.data_valid = 0;
            if (ifa.busy) busy_n++;
            if (ifa.done && done_at < 0) done_at = k;
        end
        lit("done latency", done_at, 13);
        lit("busy length", busy_n, 12);

        scan_lit("A pos0", 0, 0, G0, 1'b0);
        scan_lit("A pos1", 0, 1, G0, 1'b1);
        scan_lit("A pos2", 0, 2, GB, 1'b1);
        scan_lit("A pos3", 0, 3, G5, 1'b1);
        scan_lit("A pos4", 0, 4, G0, 1'b1);
        scan_lit("A pos5", 0, 5, GB, 1'b1);
        scan_lit("A pos6", 0, 6, G3, 1'b0);
        scan_lit("A pos7", 0, 7, G1, 1'b1);
        scan_lit("B pos0", 1, 0, G0, 1'b0);
        scan_lit("B pos1", 1, 1, GB, 1'b1);
        scan_lit("B pos3", 1, 3, G5, 1'b1);
        scan_lit("B pos4", 1, 4, GB, 1'b1);
        scan_lit("B pos7", 1, 7, G1, 1'b1);
        scan_lit("C pos0", 2, 0, GD, 1'b1);
        scan_lit("C pos1", 2, 1, GD, 1'b1);
        scan_lit("C pos2", 2, 2, GB, 1'b1);
        scan_lit("C pos3", 2, 3, G9, 1'b1);
        scan_lit("C pos4", 2, 4, G9, 1'b1);
        scan_lit("C pos6", 2, 6, GD, 1'b0);

        // Accept a new sample in the done cycle.
        ifa.acl_data   = 15'b01001_10010_01111;
        ifa.data_valid = 1;
        wait_done_a(ok);
        lit("first done seen", ok, 1'b1);
        ifa.acl_data   = 15'b10001_00000_01010;
        ifa.data_valid = 1;
        @(negedge clk);
        ifa.data_valid = 0;
        lit("busy after done-cycle accept", ifa.busy, 1'b1);
        wait_done_a(ok);
        lit("second done seen", ok, 1'b1);
        @(negedge clk);
        scan_lit("D3 pos0", 0, 0, G0, 1'b1);
        scan_lit("D3 pos1", 0, 1, G1, 1'b1);
        scan_lit("D3 pos3", 0, 3, G0, 1'b1);
        scan_lit("D3 pos6", 0, 6, G1, 1'b0);
        scan_lit("D3 pos7", 0, 7, G0, 1'b1);

        // Anode dwell and rotation across a full wrap.
        cur = ifa.an;
        len = 0;
        while (ifa.an === cur && len < 20) begin
            @(negedge clk);
            len++;
        end
        for (int r = 0; r < 16; r++) begin
            cur = ifa.an;
            len = 0;
            do begin
                @(negedge clk);
                len++;
            end while (ifa.an === cur && len < 20);
            lit("anode dwell", len, R);
            lit("anode step", ifa.an, {cur[6:0], cur[7]});
        end

        // Reset in the middle of a conversion.
        ifa.acl_data = 15'b01001_10010_01111;
        ifc.acl_data = {1'b1, 7'd55, 1'b0, 7'd12, 1'b1, 7'd3};
        ifa.data_valid = 1; ifc.data_valid = 1;
        @(negedge clk);
        ifa.data_valid = 0; ifc.data_valid = 0;
        repeat (2) @(negedge clk);
        lit("busy before reset", ifa.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit("busy cleared A", ifa.busy, 1'b0);
        lit("busy cleared C", ifc.busy, 1'b0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.done || ifc.done) done_seen = 1'b1;
        end
        lit("no done after abort", done_seen, 1'b0);
        scan_lit("rst pos0", 0, 0, G0, 1'b1);
        scan_lit("rst pos6", 0, 6, G0, 1'b1);
        scan_lit("rst pos7", 0, 7, G0, 1'b1);
        scan_lit("rst C pos3", 2, 3, G0, 1'b1);
        ifa.disp_en = 0;
        repeat (2) @(negedge clk);
        lit("disp_en off", ifa.an, 8'hFF);
        ifa.disp_en = 1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
